// File: rtl/vector_dac_arbiter.sv
// Per-segment arbiter sharing one X/Y DAC pair between two point streams.
// Accepted points are held for DWELL cycles; a stalled owner is dropped after MAX_GAP idle cycles.
module vector_dac_arbiter #(
  parameter int                    CH_WIDTH = 8,
  parameter int                    DWELL    = 4,
  parameter int                    MAX_GAP  = 64,
  parameter logic [CH_WIDTH-1:0]   PARK_X   = '0,
  parameter logic [CH_WIDTH-1:0]   PARK_Y   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [CH_WIDTH-1:0] req0_x,
  input  logic [CH_WIDTH-1:0] req0_y,
  input  logic                req0_last,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [CH_WIDTH-1:0] req1_x,
  input  logic [CH_WIDTH-1:0] req1_y,
  input  logic                req1_last,
  output logic [CH_WIDTH-1:0] x_ch,
  output logic [CH_WIDTH-1:0] y_ch,
  output logic [1:0]          grant,
  output logic                seg_done,
  output logic                timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int DW = (DWELL   > 1) ? $clog2(DWELL)   : 1;
  localparam int GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;
  localparam logic [DW-1:0] DWELL_INIT = DW'(DWELL - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(MAX_GAP - 1);

  logic [1:0]          state;
  logic                ptr;
  logic [DW-1:0]       dwell_cnt;
  logic [GW-1:0]       gap_cnt;
  logic                last_q;

  logic                own_valid;
  logic                own_last;
  logic [CH_WIDTH-1:0] own_x;
  logic [CH_WIDTH-1:0] own_y;

  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign own_last  = grant[1] ? req1_last  : req0_last;
  assign own_x     = grant[1] ? req1_x     : req0_x;
  assign own_y     = grant[1] ? req1_y     : req0_y;

  assign req0_ready = (state == OWN) && grant[0];
  assign req1_ready = (state == OWN) && grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= 1'b0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      last_q    <= 1'b0;
      x_ch      <= PARK_X;
      y_ch      <= PARK_Y;
      seg_done  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      seg_done <= 1'b0;
      timeout  <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        grant     <= '0;
        dwell_cnt <= '0;
        gap_cnt   <= '0;
        last_q    <= 1'b0;
        x_ch      <= PARK_X;
        y_ch      <= PARK_Y;
      end else begin
        case (state)
          IDLE: begin
            gap_cnt <= '0;
            if (req0_valid || req1_valid) begin
              state <= OWN;
              if (req0_valid && req1_valid) grant <= ptr ? 2'b10 : 2'b01;
              else                          grant <= req0_valid ? 2'b01 : 2'b10;
            end
          end
          OWN: begin
            if (own_valid) begin
              x_ch      <= own_x;
              y_ch      <= own_y;
              last_q    <= own_last;
              dwell_cnt <= DWELL_INIT;
              gap_cnt   <= '0;
              state     <= HOLD;
            end else if (gap_cnt == GAP_LAST) begin
              timeout <= 1'b1;
              grant   <= '0;
              ptr     <= grant[0];
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end else if (last_q) begin
              // releasing owner hands preference to the other requester
              seg_done <= 1'b1;
              grant    <= '0;
              ptr      <= grant[0];
              state    <= IDLE;
            end else begin
              state <= OWN;
            end
          end
          default: begin
            state <= IDLE;
            grant <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_dac_arbiter.sv
// Bench for vector_dac_arbiter: two instances (DWELL 4 / 1) checked each cycle against a behavioural model.
module tb_vector_dac_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en [2];
  logic       v0 [2];
  logic       v1 [2];
  logic       l0 [2];
  logic       l1 [2];
  logic       r0 [2];
  logic       r1 [2];
  logic       sd [2];
  logic       to [2];
  logic [7:0] x0 [2];
  logic [7:0] y0 [2];
  logic [7:0] x1 [2];
  logic [7:0] y1 [2];
  logic [7:0] xc [2];
  logic [7:0] yc [2];
  logic [1:0] gr [2];

  int         dwell_p [2] = '{4, 1};
  int         gap_p   [2] = '{8, 3};
  logic [7:0] park_x  [2] = '{8'h00, 8'hA5};
  logic [7:0] park_y  [2] = '{8'h00, 8'h5A};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vector_dac_arbiter #(.CH_WIDTH(8), .DWELL(4), .MAX_GAP(8), .PARK_X(8'h00), .PARK_Y(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]),
    .req0_valid(v0[0]), .req0_ready(r0[0]), .req0_x(x0[0]), .req0_y(y0[0]), .req0_last(l0[0]),
    .req1_valid(v1[0]), .req1_ready(r1[0]), .req1_x(x1[0]), .req1_y(y1[0]), .req1_last(l1[0]),
    .x_ch(xc[0]), .y_ch(yc[0]), .grant(gr[0]), .seg_done(sd[0]), .timeout(to[0]));

  vector_dac_arbiter #(.CH_WIDTH(8), .DWELL(1), .MAX_GAP(3), .PARK_X(8'hA5), .PARK_Y(8'h5A)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]),
    .req0_valid(v0[1]), .req0_ready(r0[1]), .req0_x(x0[1]), .req0_y(y0[1]), .req0_last(l0[1]),
    .req1_valid(v1[1]), .req1_ready(r1[1]), .req1_x(x1[1]), .req1_y(y1[1]), .req1_last(l1[1]),
    .x_ch(xc[1]), .y_ch(yc[1]), .grant(gr[1]), .seg_done(sd[1]), .timeout(to[1]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 none), remaining hold cycles, idle run length of owner.
  int         m_own  [2];
  int         m_hold [2];
  int         m_gap  [2];
  int         m_ptr  [2];
  logic       m_last [2];
  logic       m_sd   [2];
  logic       m_to   [2];
  logic [7:0] m_x    [2];
  logic [7:0] m_y    [2];

  task automatic m_reset(int i);
    m_own[i] = -1; m_hold[i] = 0; m_gap[i] = 0; m_ptr[i] = 0; m_last[i] = 1'b0;
    m_sd[i] = 1'b0; m_to[i] = 1'b0; m_x[i] = park_x[i]; m_y[i] = park_y[i];
  endtask

  task automatic m_step(int i);
    logic va, vb, vo;
    va = v0[i]; vb = v1[i];
    m_sd[i] = 1'b0; m_to[i] = 1'b0;
    if (!en[i]) begin
      m_own[i] = -1; m_hold[i] = 0; m_gap[i] = 0; m_last[i] = 1'b0;
      m_x[i] = park_x[i]; m_y[i] = park_y[i];
    end else if (m_own[i] < 0) begin
      if (va || vb) begin
        m_own[i] = (va && vb) ? m_ptr[i] : (va ? 0 : 1);
        m_gap[i] = 0;
      end
    end else if (m_hold[i] > 0) begin
      m_hold[i]--;
      if (m_hold[i] == 0 && m_last[i]) begin
        m_sd[i] = 1'b1; m_ptr[i] = 1 - m_own[i]; m_own[i] = -1;
      end
    end else begin
      vo = (m_own[i] == 0) ? va : vb;
      if (vo) begin
        m_x[i]    = (m_own[i] == 0) ? x0[i] : x1[i];
        m_y[i]    = (m_own[i] == 0) ? y0[i] : y1[i];
        m_last[i] = (m_own[i] == 0) ? l0[i] : l1[i];
        m_hold[i] = dwell_p[i];
        m_gap[i]  = 0;
      end else begin
        m_gap[i]++;
        if (m_gap[i] == gap_p[i]) begin
          m_to[i] = 1'b1; m_ptr[i] = 1 - m_own[i]; m_own[i] = -1; m_gap[i] = 0;
        end
      end
    end
  endtask

  initial begin
    m_reset(0); m_reset(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin m_reset(0); m_reset(1); end
      else begin m_step(0); m_step(1); end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_grant", i), gr[i], (m_own[i] < 0) ? 0 : ((m_own[i] == 0) ? 1 : 2));
        chk($sformatf("u%0d_x", i), xc[i], m_x[i]);
        chk($sformatf("u%0d_y", i), yc[i], m_y[i]);
        chk($sformatf("u%0d_ready0", i), r0[i], (m_own[i] == 0 && m_hold[i] == 0) ? 1 : 0);
        chk($sformatf("u%0d_ready1", i), r1[i], (m_own[i] == 1 && m_hold[i] == 0) ? 1 : 0);
        chk($sformatf("u%0d_seg_done", i), sd[i], m_sd[i]);
        chk($sformatf("u%0d_timeout", i), to[i], m_to[i]);
      end
    end
  end

  logic [1:0] gseq [$];
  bit         mon_on = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && (gseq.size() == 0 || gseq[gseq.size()-1] != gr[0])) gseq.push_back(gr[0]);
    end
  end

  // Offer one point and wait (bounded) for its handshake; returns at edge+1 with hs = edge count.
  task automatic send(int i, int r, logic [7:0] x, logic [7:0] y, logic last, output int hs);
    bit done;
    done = 1'b0;
    hs = -1;
    if (r == 0) begin v0[i] = 1'b1; x0[i] = x; y0[i] = y; l0[i] = last; end
    else        begin v1[i] = 1'b1; x1[i] = x; y1[i] = y; l1[i] = last; end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if ((r == 0) ? r0[i] : r1[i]) begin
        @(posedge clk); #1;
        hs = cyc;
        done = 1'b1;
      end
    end
    chk($sformatf("u%0d_req%0d_handshake", i, r), done, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, t4, sdn, sdc, c0, tcy;
    logic [1:0] tgr;
    bit found;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0; l0[i] = 1'b0; l1[i] = 1'b0;
      x0[i] = '0; y0[i] = '0; x1[i] = '0; y1[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_x0", xc[0], 8'h00);
    chk("rst_x1", xc[1], 8'hA5);
    chk("rst_y1", yc[1], 8'h5A);
    chk("rst_grant", gr[0], 2'b00);
    chk("rst_ready", r0[0], 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single segment on DWELL=4 instance
    send(0, 0, 8'd10, 8'd20, 1'b0, t1);
    chk("seg_x1", xc[0], 8'd10);
    chk("seg_y1", yc[0], 8'd20);
    chk("seg_grant", gr[0], 2'b01);
    send(0, 0, 8'd30, 8'd40, 1'b1, t2);
    v0[0] = 1'b0;
    chk("seg_x2", xc[0], 8'd30);
    chk("seg_y2", yc[0], 8'd40);
    chk("seg_spacing", t2 - t1, 5);
    sdn = 0; sdc = -1;
    repeat (10) begin
      @(negedge clk);
      if (sd[0]) begin sdn++; sdc = cyc; chk("seg_done_grant", gr[0], 2'b00); end
    end
    chk("seg_done_count", sdn, 1);
    chk("seg_done_time", sdc, t2 + 4);

    // Contention from reset: req0, req1, then req0 again
    pulse_reset();
    gseq.delete();
    mon_on = 1'b1;
    v1[0] = 1'b1; x1[0] = 8'd77; y1[0] = 8'd88; l1[0] = 1'b0;
    send(0, 0, 8'd1, 8'd2, 1'b0, t1);
    send(0, 0, 8'd3, 8'd4, 1'b1, t2);
    v0[0] = 1'b0;
    send(0, 1, 8'd77, 8'd88, 1'b0, t3);
    chk("cont_req1_x", xc[0], 8'd77);
    send(0, 1, 8'd99, 8'd100, 1'b1, t4);
    v1[0] = 1'b1; x1[0] = 8'd7; y1[0] = 8'd8; l1[0] = 1'b1;
    send(0, 0, 8'd5, 8'd6, 1'b1, t1);
    v0[0] = 1'b0;
    mon_on = 1'b0;
    chk("cont_seq_len", gseq.size(), 6);
    if (gseq.size() == 6) begin
      chk("cont_seq0", gseq[0], 2'b00);
      chk("cont_seq1", gseq[1], 2'b01);
      chk("cont_seq2", gseq[2], 2'b00);
      chk("cont_seq3", gseq[3], 2'b10);
      chk("cont_seq4", gseq[4], 2'b00);
      chk("cont_seq5", gseq[5], 2'b01);
    end
    send(0, 1, 8'd7, 8'd8, 1'b1, t2);
    v1[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Stalled owner: req0 granted, drops valid, req1 waiting
    pulse_reset();
    v1[0] = 1'b1; x1[0] = 8'd44; y1[0] = 8'd45; l1[0] = 1'b1;
    v0[0] = 1'b1; x0[0] = 8'd12; y0[0] = 8'd13; l0[0] = 1'b0;
    @(posedge clk); #1 v0[0] = 1'b0;
    chk("to_grant_req0", gr[0], 2'b01);
    c0 = cyc; found = 1'b0; tcy = -1; tgr = 2'b11;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (to[0]) begin found = 1'b1; tcy = cyc; tgr = gr[0]; end
    end
    chk("to_seen", found, 1);
    chk("to_time", tcy, c0 + 8);
    chk("to_grant_cleared", tgr, 2'b00);
    @(negedge clk);
    chk("to_regrant_req1", gr[0], 2'b10);
    send(0, 1, 8'd44, 8'd45, 1'b1, t1);
    v1[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Abort mid-HOLD, then re-grant after one IDLE cycle
    send(0, 0, 8'd55, 8'd66, 1'b0, t1);
    chk("abort_pt_x", xc[0], 8'd55);
    en[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_park_x", xc[0], 8'h00);
    chk("abort_park_y", yc[0], 8'h00);
    chk("abort_grant", gr[0], 2'b00);
    chk("abort_ready", r0[0], 1'b0);
    en[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_regrant", gr[0], 2'b01);
    send(0, 0, 8'd57, 8'd67, 1'b1, t1);
    v0[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset mid-HOLD
    send(0, 0, 8'd11, 8'd12, 1'b0, t1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_x0", xc[0], 8'h00);
    chk("areset_grant", gr[0], 2'b00);
    chk("areset_x1", xc[1], 8'hA5);
    v0[0] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // DWELL=1 stream on req1
    t2 = -1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] px, py;
      px = 8'(k * 17 + 3);
      py = 8'(255 - k * 5);
      send(1, 1, px, py, (k == 7), t1);
      chk("d1_x", xc[1], px);
      chk("d1_y", yc[1], py);
      if (k > 0) chk("d1_spacing", t1 - t2, 2);
      t2 = t1;
    end
    v1[1] = 1'b0;
    repeat (4) @(posedge clk);

    // Randomised traffic: dense then sparse valids, rare aborts and resets
    for (int ph = 0; ph < 2; ph++) begin
      repeat (2000) begin
        @(posedge clk); #1;
        rst_n = ($urandom_range(0, 599) != 0);
        for (int i = 0; i < 2; i++) begin
          en[i] = ($urandom_range(0, 63) != 0);
          v0[i] = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          v1[i] = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          x0[i] = 8'($urandom); y0[i] = 8'($urandom);
          x1[i] = 8'($urandom); y1[i] = 8'($urandom);
          l0[i] = ($urandom_range(0, 3) == 0);
          l1[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
